// File: rtl/shiftaddmul_pkg.sv
// rtl/shiftaddmul_pkg.sv - shared types and defaults for the shift-add multiplier arbiter
package shiftaddmul_pkg;

    localparam int DEFAULT_N = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    typedef logic req_id_t;

endpackage

// File: rtl/shiftaddmul_core.sv
// rtl/shiftaddmul_core.sv - N-cycle unsigned shift-add multiplier; stop rises N cycles after the start cycle
module shiftaddmul_core
    import shiftaddmul_pkg::*;
#(
    parameter int N = DEFAULT_N
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           start,
    input  logic [N-1:0]   i_B,
    input  logic [N-1:0]   i_Q,
    output logic           stop,
    output logic [2*N-1:0] o_A
);

    localparam int CW = $clog2(N + 1);

    logic [2*N-1:0] acc;
    logic [2*N-1:0] b_sh;
    logic [N-1:0]   q_sh;
    logic [CW-1:0]  cnt;
    logic           running;

    // The start edge already performs the first partial-product step, so N steps finish N cycles after start.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc     <= '0;
            b_sh    <= '0;
            q_sh    <= '0;
            cnt     <= '0;
            running <= 1'b0;
        end else if (start) begin
            acc     <= i_Q[0] ? {{N{1'b0}}, i_B} : '0;
            b_sh    <= {{N{1'b0}}, i_B} << 1;
            q_sh    <= i_Q >> 1;
            cnt     <= CW'(1);
            running <= 1'b1;
        end else if (running) begin
            if (cnt == CW'(N)) begin
                running <= 1'b0;
            end else begin
                acc  <= acc + (q_sh[0] ? b_sh : '0);
                b_sh <= b_sh << 1;
                q_sh <= q_sh >> 1;
                cnt  <= cnt + CW'(1);
            end
        end
    end

    // Stop is a single-cycle strobe once all N steps are accumulated.
    always_comb begin
        stop = running && (cnt == CW'(N));
        o_A  = acc;
    end

endmodule

// File: rtl/shiftaddmul_arbiter.sv
// rtl/shiftaddmul_arbiter.sv - two-requester arbiter around the shift-add multiplier; SHIFTADDMUL_ARB_FIXED_PRIO_EN selects fixed priority
module shiftaddmul_arbiter
    import shiftaddmul_pkg::*;
#(
    parameter int N = DEFAULT_N
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           req0_valid,
    output logic           req0_ready,
    input  logic [N-1:0]   req0_b,
    input  logic [N-1:0]   req0_q,
    input  logic           req1_valid,
    output logic           req1_ready,
    input  logic [N-1:0]   req1_b,
    input  logic [N-1:0]   req1_q,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output req_id_t        rsp_id,
    output logic [2*N-1:0] rsp_a,
    output logic           busy
);

    state_t         state;
    state_t         next_state;
    logic           grant0;
    logic           grant1;
    logic [N-1:0]   op_b;
    logic [N-1:0]   op_q;
    req_id_t        op_id;
    logic           core_start;
    logic           core_stop;
    logic [2*N-1:0] core_a;

`ifndef SHIFTADDMUL_ARB_FIXED_PRIO_EN
    req_id_t        prio;

    // Favoured requester flips to the one not just served, once its result is consumed.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prio <= 1'b0;
        end else if (state == ST_DONE && rsp_ready) begin
            prio <= ~rsp_id;
        end
    end
`endif

    // Pick exactly one winner among the valid requesters.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (req0_valid && req1_valid) begin
`ifdef SHIFTADDMUL_ARB_FIXED_PRIO_EN
            grant0 = 1'b1;
`else
            grant0 = (prio == 1'b0);
            grant1 = (prio == 1'b1);
`endif
        end else begin
            grant0 = req0_valid;
            grant1 = req1_valid;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: if (grant0 || grant1) next_state = ST_LOAD;
            ST_LOAD: next_state = ST_RUN;
            ST_RUN:  if (core_stop) next_state = ST_DONE;
            ST_DONE: if (rsp_ready) next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    // Outputs decoded from state; grants only exist while idle.
    always_comb begin
        req0_ready = (state == ST_IDLE) && grant0;
        req1_ready = (state == ST_IDLE) && grant1;
        core_start = (state == ST_LOAD);
        rsp_valid  = (state == ST_DONE);
        busy       = (state != ST_IDLE);
    end

    // Operand latch on acceptance and result capture on core stop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_b   <= '0;
            op_q   <= '0;
            op_id  <= 1'b0;
            rsp_a  <= '0;
            rsp_id <= 1'b0;
        end else begin
            if (state == ST_IDLE && (grant0 || grant1)) begin
                op_b  <= grant0 ? req0_b : req1_b;
                op_q  <= grant0 ? req0_q : req1_q;
                op_id <= grant1;
            end
            if (state == ST_RUN && core_stop) begin
                rsp_a  <= core_a;
                rsp_id <= op_id;
            end
        end
    end

    shiftaddmul_core #(
        .N (N)
    ) u_core (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (core_start),
        .i_B     (op_b),
        .i_Q     (op_q),
        .stop    (core_stop),
        .o_A     (core_a)
    );

endmodule

// File: tb/tb_shiftaddmul_arbiter.sv
// tb/tb_shiftaddmul_arbiter.sv - randomized self-checking bench for shiftaddmul_arbiter against a transaction-level model
module tb_shiftaddmul_arbiter;

    localparam int N   = 8;
    localparam int LAT = N + 2;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic           req0_valid = 1'b0;
    logic           req1_valid = 1'b0;
    logic [N-1:0]   req0_b = '0;
    logic [N-1:0]   req0_q = '0;
    logic [N-1:0]   req1_b = '0;
    logic [N-1:0]   req1_q = '0;
    logic           rsp_ready = 1'b0;
    logic           req0_ready;
    logic           req1_ready;
    logic           rsp_valid;
    logic           rsp_id;
    logic [2*N-1:0] rsp_a;
    logic           busy;

    int vectors = 0;
    int miscompares = 0;

    // transaction-level model
    bit m_busy;
    int m_cnt;
    int m_id;
    int m_prod;
    int m_prio;
    int m_rsp_a;
    int m_rsp_id;

    // what the last tick observed
    int obs_grant;
    bit obs_valid;
    int obs_a;
    int obs_id;

    always #5 clk = ~clk;

    shiftaddmul_arbiter #(.N(N)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_b     (req0_b),
        .req0_q     (req0_q),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_b     (req1_b),
        .req1_q     (req1_q),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_a      (rsp_a),
        .busy       (busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_busy   = 0;
        m_cnt    = 0;
        m_id     = 0;
        m_prod   = 0;
        m_prio   = 0;
        m_rsp_a  = 0;
        m_rsp_id = 0;
    endtask

    // Called just after a falling edge with inputs already driven; compares, advances the model, waits for the next falling edge.
    task automatic tick();
        int e0;
        int e1;
        #1;
        if (!reset_n) model_reset();
        e0 = 0;
        e1 = 0;
        if (!m_busy) begin
            if (req0_valid && req1_valid) begin
`ifdef SHIFTADDMUL_ARB_FIXED_PRIO_EN
                e0 = 1;
`else
                if (m_prio == 0) e0 = 1; else e1 = 1;
`endif
            end else begin
                e0 = int'(req0_valid);
                e1 = int'(req1_valid);
            end
        end
        chk("req0_ready", req0_ready, e0);
        chk("req1_ready", req1_ready, e1);
        chk("busy", busy, m_busy);
        chk("rsp_valid", rsp_valid, (m_busy && m_cnt == LAT) ? 1 : 0);
        chk("rsp_a", rsp_a, m_rsp_a);
        chk("rsp_id", rsp_id, m_rsp_id);
        obs_grant = req0_ready ? 0 : (req1_ready ? 1 : -1);
        obs_valid = rsp_valid;
        obs_a     = int'(rsp_a);
        obs_id    = int'(rsp_id);
        if (reset_n) begin
            if (!m_busy) begin
                if (e0 != 0 || e1 != 0) begin
                    m_busy = 1;
                    m_cnt  = 1;
                    m_id   = e1;
                    m_prod = (e1 != 0) ? int'(req1_b) * int'(req1_q) : int'(req0_b) * int'(req0_q);
                end
            end else if (m_cnt < LAT) begin
                m_cnt++;
                if (m_cnt == LAT) begin
                    m_rsp_a  = m_prod;
                    m_rsp_id = m_id;
                end
            end else if (rsp_ready) begin
                m_busy = 0;
                m_prio = 1 - m_id;
            end
        end
        @(negedge clk);
    endtask

    // One full transaction; hold = cycles spent in DONE with rsp_ready low while both valids stay high.
    task automatic run_txn(input bit v0, input bit v1, input int b0, input int q0, input int b1, input int q1,
                           input int hold, output int gid, output int a, output int id, output int lat);
        req0_valid = v0;
        req1_valid = v1;
        req0_b = N'(b0);
        req0_q = N'(q0);
        req1_b = N'(b1);
        req1_q = N'(q1);
        rsp_ready = 1'b0;
        tick();
        gid = obs_grant;
        req0_valid = (hold > 0);
        req1_valid = (hold > 0);
        rsp_ready  = (hold == 0);
        lat = 0;
        a   = -1;
        id  = -1;
        for (int n = 1; n <= 40; n++) begin
            tick();
            if (obs_valid) begin
                lat = n;
                a   = obs_a;
                id  = obs_id;
                break;
            end
        end
        if (lat == 0) chk("rsp_timeout", 0, 1);
        if (hold > 0 && lat != 0) begin
            for (int k = 1; k < hold; k++) tick();
            req0_valid = 1'b0;
            req1_valid = 1'b0;
            rsp_ready  = 1'b1;
            tick();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready  = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int gid;
        int a;
        int id;
        int lat;
        int exp_g;
        model_reset();
        @(negedge clk);
        tick();
        tick();
        reset_n = 1'b1;
        tick();

        // contention right after reset
        for (int i = 0; i < 4; i++) begin
`ifdef SHIFTADDMUL_ARB_FIXED_PRIO_EN
            exp_g = 0;
`else
            exp_g = i % 2;
`endif
            run_txn(1, 1, 3 + i, 7, 11, 13 + i, 0, gid, a, id, lat);
            chk("contention_grant", gid, exp_g);
            chk("contention_id", id, exp_g);
        end

        run_txn(1, 0, 17, 46, 0, 0, 0, gid, a, id, lat);
        chk("basic_grant", gid, 0);
        chk("basic_product", a, 782);
        chk("basic_latency", lat, 10);
        chk("basic_id", id, 0);

        run_txn(0, 1, 0, 0, 255, 255, 0, gid, a, id, lat);
        chk("max_product", a, 65025);
        chk("max_id", id, 1);

        run_txn(1, 0, 0, 200, 0, 0, 5, gid, a, id, lat);
        chk("zero_product", a, 0);
        chk("zero_latency", lat, 10);
        chk("hold_after_a", rsp_a, 0);

        // reset in the middle of RUN
        req1_valid = 1'b1;
        req1_b = 8'd9;
        req1_q = 8'd9;
        tick();
        req1_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        reset_n = 1'b0;
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_a", rsp_a, 0);
        reset_n = 1'b1;
        for (int i = 0; i < 15; i++) begin
            tick();
            chk("rst_no_response", obs_valid, 0);
        end
        run_txn(0, 1, 0, 0, 3, 5, 0, gid, a, id, lat);
        chk("post_rst_grant", gid, 1);
        chk("post_rst_product", a, 15);

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            req0_valid = 1'($urandom_range(0, 1));
            req1_valid = 1'($urandom_range(0, 1));
            req0_b = ($urandom_range(0, 7) == 0) ? 8'hFF : N'($urandom);
            req0_q = ($urandom_range(0, 7) == 0) ? 8'h00 : N'($urandom);
            req1_b = ($urandom_range(0, 7) == 0) ? 8'h00 : N'($urandom);
            req1_q = ($urandom_range(0, 7) == 0) ? 8'hFF : N'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
            reset_n = ($urandom_range(0, 199) != 0);
            tick();
        end
        reset_n = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
